// File: rtl/combine_cb_engine_pkg.sv
// Shared types and constants for the combine code-block engine:
// FSM state encodings, LLR lane geometry and the lane saturation helper.
package combine_pkg;

    localparam int unsigned LLR_W        = 32'd8;
    localparam logic [7:0]  LLR_MAX      = 8'h7f;
    localparam logic [7:0]  LLR_MIN      = 8'h80;
    localparam int unsigned USER_NUM     = 32'd8;
    localparam logic [3:0]  INVALID_USER = 4'hf;

    // One-hot state encodings; anything else is treated as illegal.
    typedef enum logic [7:0] {
        ST_IDLE    = 8'h01,
        ST_ISSUE   = 8'h02,
        ST_DRAIN   = 8'h04,
        ST_DONE    = 8'h08,
        ST_RELEASE = 8'h10
    } cb_state_e;

    // Clamp a 9-bit signed sum back into the signed 8-bit LLR range.
    // Overflow shows up as disagreement between the two top sum bits.
    function automatic logic [LLR_W-1:0] sat_llr9(input logic [LLR_W:0] sum9);
        logic [LLR_W-1:0] res;
        if (sum9[LLR_W] != sum9[LLR_W-1]) begin
            if (sum9[LLR_W]) begin
                res = LLR_MIN;
            end else begin
                res = LLR_MAX;
            end
        end else begin
            res = sum9[LLR_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/combine_cb_engine_if.sv
// RAM-side bus of the combine engine: input-buffer read port, HARQ cache
// read port and HARQ cache write port. The engine is the master.
interface combine_cb_engine_if #(
    parameter int unsigned DATA_WIDTH = 32'd48,
    parameter int unsigned ADDR_WIDTH = 32'd11
);
    logic                  o_ib_rd_en;
    logic [ADDR_WIDTH-1:0] o_ib_rd_addr;
    logic [DATA_WIDTH-1:0] i_ib_rd_data;
    logic                  o_cache_rd_en;
    logic [ADDR_WIDTH+1:0] o_cache_rd_addr;
    logic [DATA_WIDTH-1:0] i_cache_rd_data;
    logic                  o_cache_wr_en;
    logic [ADDR_WIDTH+1:0] o_cache_wr_addr;
    logic [DATA_WIDTH-1:0] o_cache_wr_data;

    modport master (
        output o_ib_rd_en, o_ib_rd_addr, input i_ib_rd_data,
        output o_cache_rd_en, o_cache_rd_addr, input i_cache_rd_data,
        output o_cache_wr_en, o_cache_wr_addr, o_cache_wr_data
    );

    modport slave (
        input o_ib_rd_en, o_ib_rd_addr, output i_ib_rd_data,
        input o_cache_rd_en, o_cache_rd_addr, output i_cache_rd_data,
        input o_cache_wr_en, o_cache_wr_addr, o_cache_wr_data
    );
endinterface

// File: rtl/combine_cb_engine_llr_sat_add.sv
// Single-lane signed 8-bit saturating adder (purely combinational).
module llr_sat_add
    import combine_pkg::*;
(
    input  logic [LLR_W-1:0] a,
    input  logic [LLR_W-1:0] b,
    output logic [LLR_W-1:0] y
);

    logic [LLR_W:0] sum_s;

    // Sign-extend both operands into a 9-bit sum, then clamp to 8 bits
    always_comb begin
        sum_s = {a[LLR_W-1], a} + {b[LLR_W-1], b};
        y     = sat_llr9(sum_s);
    end

endmodule

// File: rtl/combine_cb_engine.sv
// Combine responder: on a scheduler request, streams one user's code block
// from the active input-buffer bank, saturating-adds it lane-wise onto the
// HARQ cache and writes the result back, then pulses completion and flips
// that user's ping-pong bank.
module combine_cb_engine
    import combine_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32'd48,
    parameter int unsigned ADDR_WIDTH = 32'd11
) (
    input  logic                    i_core_clk,
    input  logic                    i_rx_rstn,
    input  logic                    i_Combine_process_request,
    input  logic [3:0]              i_Combine_user_index,
    input  logic [8*ADDR_WIDTH-1:0] i_user_cb_len,
    combine_cb_engine_if.master     ram,
    output logic                    o_current_cb_combine_comp,
    output logic [7:0]              o_PingPong_rd_bank,
    output logic                    o_busy
);

    localparam int unsigned LANES = DATA_WIDTH / LLR_W;
    localparam int unsigned OFF_W = ADDR_WIDTH - 32'd1;
    localparam logic [ADDR_WIDTH-1:0] BANK_WORDS = {1'b1, {OFF_W{1'b0}}};
    localparam logic [ADDR_WIDTH-1:0] LEN_ONE    = {{OFF_W{1'b0}}, 1'b1};
    localparam logic [OFF_W-1:0]      OFF_ONE    = {{(OFF_W-1){1'b0}}, 1'b1};

    cb_state_e             state_r;
    logic [2:0]            user_r;
    logic [ADDR_WIDTH-1:0] len_r;
    logic [OFF_W-1:0]      off_r;
    logic                  rd_en_r;
    logic [ADDR_WIDTH-1:0] ib_addr_r;
    logic [ADDR_WIDTH+1:0] cache_addr_r;
    logic                  comp_r;
    logic [7:0]            bank_r;
    logic                  busy_r;

    logic                  s1_vld_r;
    logic [ADDR_WIDTH+1:0] s1_addr_r;
    logic                  wr_en_r;
    logic [ADDR_WIDTH+1:0] wr_addr_r;
    logic [DATA_WIDTH-1:0] wr_data_r;

    logic                  req_valid_s;
    logic [2:0]            req_user_s;
    logic [ADDR_WIDTH-1:0] req_len_raw_s;
    logic [ADDR_WIDTH-1:0] req_len_s;
    logic                  last_s;
    logic [DATA_WIDTH-1:0] sum_s;

    // Decode the incoming request: user range check and bank-size clamp of L
    always_comb begin
        req_user_s    = i_Combine_user_index[2:0];
        req_valid_s   = i_Combine_process_request
                        && (i_Combine_user_index != INVALID_USER)
                        && (32'(i_Combine_user_index) < USER_NUM);
        req_len_raw_s = i_user_cb_len[32'(req_user_s) * ADDR_WIDTH +: ADDR_WIDTH];
        if (req_len_raw_s > BANK_WORDS) begin
            req_len_s = BANK_WORDS;
        end else begin
            req_len_s = req_len_raw_s;
        end
        last_s = ({1'b0, off_r} == (len_r - LEN_ONE));
    end

    // Control FSM: request acceptance, read issue, drain, completion, release
    always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
        if (!i_rx_rstn) begin
            state_r      <= ST_IDLE;
            user_r       <= 3'd0;
            len_r        <= '0;
            off_r        <= '0;
            rd_en_r      <= 1'b0;
            ib_addr_r    <= '0;
            cache_addr_r <= '0;
            comp_r       <= 1'b0;
            bank_r       <= 8'h00;
            busy_r       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    comp_r <= 1'b0;
                    if (req_valid_s) begin
                        user_r <= req_user_s;
                        len_r  <= req_len_s;
                        off_r  <= '0;
                        busy_r <= 1'b1;
                        if (req_len_s == '0) begin
                            rd_en_r <= 1'b0;
                            state_r <= ST_DRAIN;
                        end else begin
                            rd_en_r      <= 1'b1;
                            ib_addr_r    <= {bank_r[req_user_s], {OFF_W{1'b0}}};
                            cache_addr_r <= {req_user_s, {OFF_W{1'b0}}};
                            state_r      <= ST_ISSUE;
                        end
                    end else begin
                        rd_en_r <= 1'b0;
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    if (last_s) begin
                        rd_en_r <= 1'b0;
                        state_r <= ST_DRAIN;
                    end else begin
                        off_r        <= off_r + OFF_ONE;
                        rd_en_r      <= 1'b1;
                        ib_addr_r    <= {bank_r[user_r], off_r + OFF_ONE};
                        cache_addr_r <= {user_r, off_r + OFF_ONE};
                        state_r      <= ST_ISSUE;
                    end
                end
                ST_DRAIN: begin
                    // Last write is leaving stage 2 now, so comp lands right behind it
                    if (!rd_en_r && !s1_vld_r) begin
                        comp_r         <= 1'b1;
                        bank_r[user_r] <= ~bank_r[user_r];
                        state_r        <= ST_DONE;
                    end else begin
                        state_r <= ST_DRAIN;
                    end
                end
                ST_DONE: begin
                    comp_r  <= 1'b0;
                    state_r <= ST_RELEASE;
                end
                ST_RELEASE: begin
                    if (!i_Combine_process_request) begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_RELEASE;
                    end
                end
                default: begin
                    rd_en_r <= 1'b0;
                    comp_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // One saturating adder per LLR lane
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        llr_sat_add u_lane_add (
            .a (ram.i_ib_rd_data[g*LLR_W +: LLR_W]),
            .b (ram.i_cache_rd_data[g*LLR_W +: LLR_W]),
            .y (sum_s[g*LLR_W +: LLR_W])
        );
    end

    // Two-stage datapath: stage 1 tracks the in-flight read, stage 2 is the write
    always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
        if (!i_rx_rstn) begin
            s1_vld_r  <= 1'b0;
            s1_addr_r <= '0;
            wr_en_r   <= 1'b0;
            wr_addr_r <= '0;
            wr_data_r <= '0;
        end else begin
            s1_vld_r  <= rd_en_r;
            s1_addr_r <= cache_addr_r;
            wr_en_r   <= s1_vld_r;
            wr_addr_r <= s1_addr_r;
            if (s1_vld_r) begin
                wr_data_r <= sum_s;
            end else begin
                wr_data_r <= wr_data_r;
            end
        end
    end

    assign ram.o_ib_rd_en       = rd_en_r;
    assign ram.o_ib_rd_addr     = ib_addr_r;
    assign ram.o_cache_rd_en    = rd_en_r;
    assign ram.o_cache_rd_addr  = cache_addr_r;
    assign ram.o_cache_wr_en    = wr_en_r;
    assign ram.o_cache_wr_addr  = wr_addr_r;
    assign ram.o_cache_wr_data  = wr_data_r;
    assign o_current_cb_combine_comp = comp_r;
    assign o_PingPong_rd_bank   = bank_r;
    assign o_busy               = busy_r;

endmodule

// File: tb/tb_combine_cb_engine.sv
// Scoreboard bench for combine_cb_engine: the driver pushes expected reads,
// writes and completions (computed from the block's rules) into queues and a
// negedge monitor pops and compares whatever the DUT presents.
module tb_combine_cb_engine;

    localparam int DW  = 48;
    localparam int AW  = 11;
    localparam int CAW = AW + 2;
    localparam int OW  = AW - 1;
    localparam int LN  = DW / 8;
    localparam int BW  = 1 << OW;

    typedef struct { int cyc; logic [AW-1:0] ib; logic [CAW-1:0] ca; } rd_t;
    typedef struct { int cyc; logic [CAW-1:0] ad; logic [DW-1:0] dt; } wr_t;
    typedef struct { int cyc; logic [7:0] bk; } cp_t;

    logic clk;
    logic rst_n;
    logic req;
    logic [3:0] idx;
    logic [8*AW-1:0] cb_len;
    logic comp;
    logic [7:0] bank;
    logic busy;

    rd_t rd_q[$];
    wr_t wr_q[$];
    cp_t cp_q[$];
    rd_t mon_r;
    wr_t mon_w;
    cp_t mon_c;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    logic [7:0] mbank = 8'h00;
    logic [DW-1:0] ib_ram [0:(1<<AW)-1];
    logic [DW-1:0] cache_ram [0:(1<<CAW)-1];

    combine_cb_engine_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ram_if ();

    combine_cb_engine #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .i_core_clk                (clk),
        .i_rx_rstn                 (rst_n),
        .i_Combine_process_request (req),
        .i_Combine_user_index      (idx),
        .i_user_cb_len             (cb_len),
        .ram                       (ram_if),
        .o_current_cb_combine_comp (comp),
        .o_PingPong_rd_bank        (bank),
        .o_busy                    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read RAM models, one cycle of latency
    always @(posedge clk) begin
        if (ram_if.o_ib_rd_en) ram_if.i_ib_rd_data <= ib_ram[ram_if.o_ib_rd_addr];
        if (ram_if.o_cache_rd_en) ram_if.i_cache_rd_data <= cache_ram[ram_if.o_cache_rd_addr];
    end

    task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference lane arithmetic: signed add, clamp to [-128, 127]
    function automatic logic [DW-1:0] satword(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW-1:0] r;
        int s;
        for (int i = 0; i < LN; i++) begin
            s = int'($signed(a[i*8 +: 8])) + int'($signed(b[i*8 +: 8]));
            if (s > 127) s = 127;
            if (s < -128) s = -128;
            r[i*8 +: 8] = s[7:0];
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] w;
        for (int i = 0; i < LN; i++) begin
            case ($urandom_range(0, 5))
                0: w[i*8 +: 8] = 8'h7f;
                1: w[i*8 +: 8] = 8'h80;
                2: w[i*8 +: 8] = 8'h01;
                3: w[i*8 +: 8] = 8'hff;
                default: w[i*8 +: 8] = 8'($urandom);
            endcase
        end
        return w;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one CB request and push everything the DUT should produce for it
    task automatic run_cb(input int u, input int len, input int drop_at, input int hold, input bit fill);
        int c, l, b, cc;
        l = (len > BW) ? BW : len;
        b = int'(mbank[u]);
        chk(busy == 1'b0, "idle_before_req", 64'(busy), 64'(0));
        if (fill) begin
            for (int k = 0; k < l; k++) begin
                ib_ram[b*BW + k]    = rand_word();
                cache_ram[u*BW + k] = rand_word();
            end
        end
        for (int v = 0; v < 8; v++) cb_len[v*AW +: AW] = AW'($urandom);
        cb_len[u*AW +: AW] = AW'(len);
        c = cyc;
        idx = 4'(u);
        req = 1'b1;
        for (int k = 0; k < l; k++) begin
            rd_q.push_back('{c + 1 + k, AW'(b*BW + k), CAW'(u*BW + k)});
            wr_q.push_back('{c + 3 + k, CAW'(u*BW + k), satword(ib_ram[b*BW + k], cache_ram[u*BW + k])});
        end
        cc = (l == 0) ? c + 2 : c + l + 3;
        mbank[u] = ~mbank[u];
        cp_q.push_back('{cc, mbank});
        while (cyc < cc + 1 + hold) begin
            step();
            if (drop_at > 0 && cyc == c + drop_at) req = 1'b0;
            if (cyc > cc && req) chk(busy == 1'b1, "busy_in_release", 64'(busy), 64'(1));
        end
        req = 1'b0;
        step();
    endtask

    // Monitor: compare every strobe / pulse the DUT presents against the queues
    always @(negedge clk) begin
        if (rst_n) begin
            if (rd_q.size() > 0 && rd_q[0].cyc < cyc) begin
                chk(1'b0, "rd_missing", 64'(0), 64'(rd_q[0].cyc));
                rd_q.delete(0);
            end
            if (wr_q.size() > 0 && wr_q[0].cyc < cyc) begin
                chk(1'b0, "wr_missing", 64'(0), 64'(wr_q[0].cyc));
                wr_q.delete(0);
            end
            if (cp_q.size() > 0 && cp_q[0].cyc < cyc) begin
                chk(1'b0, "comp_missing", 64'(0), 64'(cp_q[0].cyc));
                cp_q.delete(0);
            end
            if (ram_if.o_ib_rd_en || ram_if.o_cache_rd_en) begin
                if (rd_q.size() == 0) begin
                    chk(1'b0, "rd_unexpected", 64'(ram_if.o_ib_rd_addr), 64'(0));
                end else begin
                    mon_r = rd_q.pop_front();
                    chk(mon_r.cyc == cyc, "rd_cycle", 64'(cyc), 64'(mon_r.cyc));
                    chk(ram_if.o_ib_rd_en && ram_if.o_cache_rd_en, "rd_strobe_pair",
                        64'({ram_if.o_ib_rd_en, ram_if.o_cache_rd_en}), 64'(3));
                    chk(ram_if.o_ib_rd_addr == mon_r.ib, "ib_rd_addr", 64'(ram_if.o_ib_rd_addr), 64'(mon_r.ib));
                    chk(ram_if.o_cache_rd_addr == mon_r.ca, "cache_rd_addr", 64'(ram_if.o_cache_rd_addr), 64'(mon_r.ca));
                end
            end
            if (ram_if.o_cache_wr_en) begin
                if (wr_q.size() == 0) begin
                    chk(1'b0, "wr_unexpected", 64'(ram_if.o_cache_wr_addr), 64'(0));
                end else begin
                    mon_w = wr_q.pop_front();
                    chk(mon_w.cyc == cyc, "wr_cycle", 64'(cyc), 64'(mon_w.cyc));
                    chk(ram_if.o_cache_wr_addr == mon_w.ad, "wr_addr", 64'(ram_if.o_cache_wr_addr), 64'(mon_w.ad));
                    chk(ram_if.o_cache_wr_data == mon_w.dt, "wr_data", 64'(ram_if.o_cache_wr_data), 64'(mon_w.dt));
                end
            end
            if (comp) begin
                if (cp_q.size() == 0) begin
                    chk(1'b0, "comp_unexpected", 64'(comp), 64'(0));
                end else begin
                    mon_c = cp_q.pop_front();
                    chk(mon_c.cyc == cyc, "comp_cycle", 64'(cyc), 64'(mon_c.cyc));
                    chk(bank == mon_c.bk, "bank_at_comp", 64'(bank), 64'(mon_c.bk));
                end
            end
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk(!ram_if.o_ib_rd_en && !ram_if.o_cache_rd_en && !ram_if.o_cache_wr_en && !comp,
            {tag, "_strobes"},
            64'({ram_if.o_ib_rd_en, ram_if.o_cache_rd_en, ram_if.o_cache_wr_en, comp}), 64'(0));
        chk(ram_if.o_ib_rd_addr == '0 && ram_if.o_cache_rd_addr == '0 && ram_if.o_cache_wr_addr == '0,
            {tag, "_addrs"}, 64'({ram_if.o_ib_rd_addr, ram_if.o_cache_rd_addr, ram_if.o_cache_wr_addr}), 64'(0));
        chk(ram_if.o_cache_wr_data == '0, {tag, "_wr_data"}, 64'(ram_if.o_cache_wr_data), 64'(0));
        chk(bank == 8'h00 && busy == 1'b0, {tag, "_bank_busy"}, 64'({bank, busy}), 64'(0));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int u, len, drop;
        rst_n  = 1'b0;
        req    = 1'b0;
        idx    = 4'd0;
        cb_len = '0;
        repeat (3) step();
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        step();

        // Directed: user 2, L=4, ib lanes 10 + cache lanes 20
        for (int k = 0; k < 4; k++) begin
            ib_ram[k]          = {LN{8'd10}};
            cache_ram[2*BW + k] = {LN{8'd20}};
        end
        run_cb(2, 4, 0, 0, 1'b0);
        chk(bank == 8'h04, "bank_after_user2", 64'(bank), 64'(8'h04));

        // Same user again reads the other bank, then the bit flips back
        run_cb(2, 4, 0, 0, 1'b1);
        chk(bank == 8'h00, "bank_after_user2_again", 64'(bank), 64'(8'h00));

        // Saturation corner words for user 3
        ib_ram[0] = {LN{8'h7f}}; cache_ram[3*BW + 0] = {LN{8'h01}};
        ib_ram[1] = {LN{8'h80}}; cache_ram[3*BW + 1] = {LN{8'hff}};
        ib_ram[2] = {LN{8'h05}}; cache_ram[3*BW + 2] = {LN{8'hfb}};
        run_cb(3, 3, 0, 0, 1'b0);

        // Empty code block
        run_cb(5, 0, 0, 0, 1'b1);
        chk(bank[5] == 1'b1, "bank5_after_empty", 64'(bank), 64'(mbank));

        // Request held after completion: must not be re-accepted
        run_cb(1, 5, 0, 6, 1'b1);

        // Invalid user indices are ignored
        idx = 4'hf;
        req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk(busy == 1'b0, "invalid_index_idle", 64'(busy), 64'(0));
        end
        for (int i = 0; i < 4; i++) begin
            idx = 4'($urandom_range(8, 14));
            step();
            chk(busy == 1'b0, "out_of_range_idle", 64'(busy), 64'(0));
        end
        req = 1'b0;
        step();

        // Randomised CBs, including mid-CB request drops and held requests
        for (int n = 0; n < 25; n++) begin
            u    = int'($urandom_range(0, 7));
            len  = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 24));
            drop = (len >= 3 && $urandom_range(0, 4) == 0) ? 2 : 0;
            run_cb(u, len, drop, int'($urandom_range(0, 3)), 1'b1);
        end

        // Length above the bank size is clamped to a full bank
        run_cb(7, 2047, 0, 0, 1'b1);

        // Reset in cycle 3 of an L=8 CB aborts everything
        begin
            int c;
            for (int k = 0; k < 8; k++) begin
                ib_ram[int'(mbank[6])*BW + k] = rand_word();
                cache_ram[6*BW + k]           = rand_word();
            end
            cb_len[6*AW +: AW] = AW'(8);
            c = cyc;
            idx = 4'd6;
            req = 1'b1;
            rd_q.push_back('{c + 1, AW'(int'(mbank[6])*BW + 0), CAW'(6*BW + 0)});
            rd_q.push_back('{c + 2, AW'(int'(mbank[6])*BW + 1), CAW'(6*BW + 1)});
            repeat (3) step();
            rst_n = 1'b0;
            req   = 1'b0;
            #1;
            chk_reset_outputs("midcb_reset");
            mbank = 8'h00;
            step();
            step();
            rst_n = 1'b1;
            repeat (12) step();
            chk(bank == 8'h00 && busy == 1'b0, "after_reset_quiet", 64'({bank, busy}), 64'(0));
        end

        chk(rd_q.size() == 0, "rd_queue_empty", 64'(rd_q.size()), 64'(0));
        chk(wr_q.size() == 0, "wr_queue_empty", 64'(wr_q.size()), 64'(0));
        chk(cp_q.size() == 0, "comp_queue_empty", 64'(cp_q.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
